// File: rtl/obstacle_pkg.sv
// Shared widths and scheduler state encoding for the obstacle display path.
package obstacle_pkg;

    localparam int SCREEN_WIDTH    = 10;
    localparam int PHY_WIDTH       = 14;
    localparam int OBSTACLE_WIDTH  = 10;
    localparam int OBSTACLE_HEIGHT = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        READY = 2'd3
    } state_t;

endpackage

// File: rtl/obstacle_slot_matcher.sv
// Combinational horizontal match of pixel_x against the scheduled slots;
// the lowest-index valid slot covering the pixel wins.
module obstacle_slot_matcher
    import obstacle_pkg::*;
#(
    parameter int SLOT_NUM   = 4,
    parameter int SLOT_IDX_W = 2
) (
    input  logic [SLOT_NUM-1:0]              slot_valid,
    input  logic [SLOT_NUM*SCREEN_WIDTH-1:0] slot_sx,
    input  logic [SCREEN_WIDTH-1:0]          pixel_x,
    output logic                             hit,
    output logic [SLOT_IDX_W-1:0]            hit_idx,
    output logic [SCREEN_WIDTH-1:0]          rom_x
);

    logic [SCREEN_WIDTH:0] px;
    logic [SCREEN_WIDTH:0] sx;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        rom_x   = '0;
        px      = {1'b0, pixel_x};
        sx      = '0;
        // Descending scan so the lowest matching index is the last one written.
        for (int i = SLOT_NUM - 1; i >= 0; i--) begin
            sx = {1'b0, slot_sx[i*SCREEN_WIDTH +: SCREEN_WIDTH]};
            if (slot_valid[i] && (px >= sx) &&
                (px < sx + (SCREEN_WIDTH+1)'(OBSTACLE_WIDTH))) begin
                hit     = 1'b1;
                hit_idx = SLOT_IDX_W'(i);
                rom_x   = pixel_x - sx[SCREEN_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/obstacle_line_scheduler.sv
// Per-scanline obstacle scheduler: scans the position table in hblank, keeps
// up to SLOT_NUM obstacles for the next line, then renders them during video.
module obstacle_line_scheduler
    import obstacle_pkg::*;
#(
    parameter int OBSTACLE_NUM = 16,
    parameter int IDX_WIDTH    = 4,
    parameter int SLOT_NUM     = 4
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    line_start,
    input  logic [SCREEN_WIDTH-1:0] line_y,
    input  logic [PHY_WIDTH-1:0]    camera_y,
    input  logic [SCREEN_WIDTH-1:0] pixel_x,
    input  logic                    video_on,
    output logic                    rd_req,
    output logic [IDX_WIDTH-1:0]    rd_idx,
    input  logic                    rd_valid,
    input  logic [PHY_WIDTH-1:0]    rd_abs_x,
    input  logic [PHY_WIDTH-1:0]    rd_abs_y,
    output logic                    obstacle_on,
    output logic [SCREEN_WIDTH-1:0] obstacle_x_rom,
    output logic [SCREEN_WIDTH-1:0] obstacle_y_rom,
    output logic [PHY_WIDTH-1:0]    obstacle_abs_pos_x,
    output logic [PHY_WIDTH-1:0]    obstacle_abs_pos_y,
    output logic                    line_ready,
    output logic                    overflow
);

    localparam int SLOT_IDX_W = (SLOT_NUM > 1) ? $clog2(SLOT_NUM) : 1;

    state_t                               state_q, state_d;
    logic [IDX_WIDTH-1:0]                 idx_q, idx_d;
    logic                                 rd_pend_q, rd_pend_d;
    logic                                 overflow_q, overflow_d;
    logic [SLOT_NUM-1:0]                  slot_valid_q, slot_valid_d;
    logic [PHY_WIDTH-1:0]                 line_abs_y_q, line_abs_y_d;
    logic [SLOT_NUM-1:0][PHY_WIDTH-1:0]   slot_x_q, slot_x_d;
    logic [SLOT_NUM-1:0][PHY_WIDTH-1:0]   slot_y_q, slot_y_d;
    logic [SLOT_NUM*SCREEN_WIDTH-1:0]     slot_sx;

    logic                                 on_q, on_d;
    logic [SCREEN_WIDTH-1:0]              x_rom_q, x_rom_d, y_rom_q, y_rom_d;
    logic [PHY_WIDTH-1:0]                 pos_x_q, pos_x_d, pos_y_q, pos_y_d;

    logic                                 line_hit;
    logic                                 free_found;
    logic                                 m_hit;
    logic [SLOT_IDX_W-1:0]                m_idx;
    logic [SCREEN_WIDTH-1:0]              m_rom_x;

    // Range check widened by one bit so abs_y + HEIGHT never wraps.
    assign line_hit = ({1'b0, line_abs_y_q} >= {1'b0, rd_abs_y}) &&
                      ({1'b0, line_abs_y_q} <
                       {1'b0, rd_abs_y} + (PHY_WIDTH+1)'(OBSTACLE_HEIGHT));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rd_pend_d    = 1'b0;
        overflow_d   = overflow_q;
        slot_valid_d = slot_valid_q;
        line_abs_y_d = line_abs_y_q;
        slot_x_d     = slot_x_q;
        slot_y_d     = slot_y_q;
        free_found   = 1'b0;
        if (line_start) begin
            state_d      = SCAN;
            idx_d        = '0;
            line_abs_y_d = camera_y + {{(PHY_WIDTH-SCREEN_WIDTH){1'b0}}, line_y};
            slot_valid_d = '0;
            overflow_d   = 1'b0;
        end else begin
            case (state_q)
                SCAN: begin
                    rd_pend_d = 1'b1;
                    idx_d     = idx_q + 1'b1;
                    if (idx_q == IDX_WIDTH'(OBSTACLE_NUM - 1)) state_d = DRAIN;
                end
                DRAIN:   state_d = READY;
                default: ;
            endcase
            // rd_pend_q marks a response to a read of the current scan only.
            if (rd_valid && rd_pend_q && line_hit) begin
                if (&slot_valid_q) begin
                    overflow_d = 1'b1;
                end else begin
                    for (int i = 0; i < SLOT_NUM; i++) begin
                        if (!slot_valid_q[i] && !free_found) begin
                            free_found      = 1'b1;
                            slot_valid_d[i] = 1'b1;
                            slot_x_d[i]     = rd_abs_x;
                            slot_y_d[i]     = rd_abs_y;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < SLOT_NUM; i++) begin
            slot_sx[i*SCREEN_WIDTH +: SCREEN_WIDTH] = slot_x_q[i][SCREEN_WIDTH-1:0];
        end
    end

    obstacle_slot_matcher #(
        .SLOT_NUM   (SLOT_NUM),
        .SLOT_IDX_W (SLOT_IDX_W)
    ) u_matcher (
        .slot_valid (slot_valid_q),
        .slot_sx    (slot_sx),
        .pixel_x    (pixel_x),
        .hit        (m_hit),
        .hit_idx    (m_idx),
        .rom_x      (m_rom_x)
    );

    always_comb begin
        on_d    = 1'b0;
        x_rom_d = '0;
        y_rom_d = '0;
        pos_x_d = '0;
        pos_y_d = '0;
        if ((state_q == READY) && video_on && m_hit) begin
            on_d    = 1'b1;
            x_rom_d = m_rom_x;
            y_rom_d = SCREEN_WIDTH'(line_abs_y_q - slot_y_q[m_idx]);
            pos_x_d = slot_x_q[m_idx];
            pos_y_d = slot_y_q[m_idx];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            rd_pend_q    <= 1'b0;
            overflow_q   <= 1'b0;
            slot_valid_q <= '0;
            on_q         <= 1'b0;
            x_rom_q      <= '0;
            y_rom_q      <= '0;
            pos_x_q      <= '0;
            pos_y_q      <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            rd_pend_q    <= rd_pend_d;
            overflow_q   <= overflow_d;
            slot_valid_q <= slot_valid_d;
            on_q         <= on_d;
            x_rom_q      <= x_rom_d;
            y_rom_q      <= y_rom_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
        end
    end

    // Slot payload and line position are qualified by slot_valid/state.
    always_ff @(posedge sys_clk) begin
        line_abs_y_q <= line_abs_y_d;
        slot_x_q     <= slot_x_d;
        slot_y_q     <= slot_y_d;
    end

    assign rd_req             = (state_q == SCAN);
    assign rd_idx             = idx_q;
    assign line_ready         = (state_q == READY);
    assign overflow           = overflow_q;
    assign obstacle_on        = on_q;
    assign obstacle_x_rom     = x_rom_q;
    assign obstacle_y_rom     = y_rom_q;
    assign obstacle_abs_pos_x = pos_x_q;
    assign obstacle_abs_pos_y = pos_y_q;

endmodule

// File: tb/tb_obstacle_line_scheduler.sv
// Directed bench for obstacle_line_scheduler with a 1-cycle-latency table model.
module tb_obstacle_line_scheduler;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        line_start = 1'b0;
    logic [9:0]  line_y = '0;
    logic [13:0] camera_y = '0;
    logic [9:0]  pixel_x = '0;
    logic        video_on = 1'b0;
    logic        rd_req;
    logic [3:0]  rd_idx;
    logic        rd_valid = 1'b0;
    logic [13:0] rd_abs_x = '0;
    logic [13:0] rd_abs_y = '0;
    logic        obstacle_on;
    logic [9:0]  obstacle_x_rom, obstacle_y_rom;
    logic [13:0] obstacle_abs_pos_x, obstacle_abs_pos_y;
    logic        line_ready, overflow;

    int total = 0;
    int bad   = 0;
    logic [13:0] tab_x [16];
    logic [13:0] tab_y [16];

    obstacle_line_scheduler dut (
        .sys_clk            (sys_clk),
        .sys_rst            (sys_rst),
        .line_start         (line_start),
        .line_y             (line_y),
        .camera_y           (camera_y),
        .pixel_x            (pixel_x),
        .video_on           (video_on),
        .rd_req             (rd_req),
        .rd_idx             (rd_idx),
        .rd_valid           (rd_valid),
        .rd_abs_x           (rd_abs_x),
        .rd_abs_y           (rd_abs_y),
        .obstacle_on        (obstacle_on),
        .obstacle_x_rom     (obstacle_x_rom),
        .obstacle_y_rom     (obstacle_y_rom),
        .obstacle_abs_pos_x (obstacle_abs_pos_x),
        .obstacle_abs_pos_y (obstacle_abs_pos_y),
        .line_ready         (line_ready),
        .overflow           (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        rd_valid <= (rd_req === 1'b1);
        if (rd_req === 1'b1) begin
            rd_abs_x <= tab_x[rd_idx];
            rd_abs_y <= tab_y[rd_idx];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_table(input int y);
        for (int i = 0; i < 16; i++) begin
            tab_x[i] = 14'd0;
            tab_y[i] = 14'(y);
        end
    endtask

    task automatic pulse_line(input int cam, input int ly);
        camera_y   = 14'(cam);
        line_y     = 10'(ly);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (line_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (line_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s line_ready timeout got=%b want=1", nm, line_ready);
        end
    endtask

    // One expected obstacle window [x0, x0+9]; en=0 means no pixel may hit.
    task automatic sweep(input int lo, input int hi, input bit en, input int x0,
                         input int yrom, input int ax, input int ay, input string nm);
        logic       exp_on;
        logic [9:0] exp_x;
        for (int p = lo; p <= hi; p++) begin
            video_on = 1'b1;
            pixel_x  = 10'(p);
            tick();
            exp_on = en && (p >= x0) && (p < x0 + 10);
            exp_x  = exp_on ? 10'(p - x0) : 10'd0;
            total++;
            if (obstacle_on !== exp_on || obstacle_x_rom !== exp_x ||
                obstacle_y_rom !== (exp_on ? 10'(yrom) : 10'd0) ||
                obstacle_abs_pos_x !== (exp_on ? 14'(ax) : 14'd0) ||
                obstacle_abs_pos_y !== (exp_on ? 14'(ay) : 14'd0)) begin
                bad++;
                $display("FAIL %s px=%0d got on=%b x=%0d y=%0d ax=%0d ay=%0d want on=%b x=%0d y=%0d",
                         nm, p, obstacle_on, obstacle_x_rom, obstacle_y_rom,
                         obstacle_abs_pos_x, obstacle_abs_pos_y, exp_on, exp_x,
                         exp_on ? yrom : 0);
            end
        end
        video_on = 1'b0;
        tick();
    endtask

    task automatic point(input int p, input int xr, input int ax, input string nm);
        video_on = 1'b1;
        pixel_x  = 10'(p);
        tick();
        total++;
        if (obstacle_on !== 1'b1 || obstacle_x_rom !== 10'(xr) ||
            obstacle_abs_pos_x !== 14'(ax)) begin
            bad++;
            $display("FAIL %s px=%0d got on=%b x=%0d ax=%0d want on=1 x=%0d ax=%0d",
                     nm, p, obstacle_on, obstacle_x_rom, obstacle_abs_pos_x, xr, ax);
        end
        video_on = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        tick();
        tick();
        total++;
        if (rd_req !== 1'b0 || rd_idx !== 4'd0 || line_ready !== 1'b0 || overflow !== 1'b0 ||
            obstacle_on !== 1'b0 || obstacle_x_rom !== 10'd0 || obstacle_y_rom !== 10'd0 ||
            obstacle_abs_pos_x !== 14'd0 || obstacle_abs_pos_y !== 14'd0) begin
            bad++;
            $display("FAIL reset_state got req=%b idx=%0d rdy=%b ovf=%b on=%b want all 0",
                     rd_req, rd_idx, line_ready, overflow, obstacle_on);
        end
        sys_rst = 1'b0;
        tick();
        total++;
        if (rd_req !== 1'b0 || line_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got req=%b rdy=%b want 0 0", rd_req, line_ready);
        end
    endtask

    task automatic test_scan_timing();
        clear_table(0);
        pulse_line(100, 5);
        for (int k = 0; k < 16; k++) begin
            total++;
            if (rd_req !== 1'b1 || rd_idx !== 4'(k) || line_ready !== 1'b0) begin
                bad++;
                $display("FAIL scan_idx cycle=%0d got req=%b idx=%0d rdy=%b want 1 %0d 0",
                         k + 1, rd_req, rd_idx, line_ready, k);
            end
            tick();
        end
        total++;
        if (rd_req !== 1'b0 || line_ready !== 1'b0) begin
            bad++;
            $display("FAIL scan_drain got req=%b rdy=%b want 0 0", rd_req, line_ready);
        end
        tick();
        total++;
        if (line_ready !== 1'b1 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL scan_ready_c18 got rdy=%b ovf=%b want 1 0", line_ready, overflow);
        end
        sweep(0, 63, 1'b0, 0, 0, 0, 0, "scan_no_hit");
    endtask

    task automatic test_single();
        clear_table(1000);
        tab_x[3] = 14'd40;
        tab_y[3] = 14'd100;
        pulse_line(100, 7);
        wait_ready("single");
        sweep(0, 63, 1'b1, 40, 7, 40, 100, "single_sweep");
        video_on = 1'b0;
        pixel_x  = 10'd45;
        tick();
        total++;
        if (obstacle_on !== 1'b0 || obstacle_x_rom !== 10'd0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL video_off got on=%b x=%0d ovf=%b want 0 0 0",
                     obstacle_on, obstacle_x_rom, overflow);
        end
    endtask

    task automatic test_priority();
        clear_table(1000);
        tab_x[2] = 14'd40;  tab_y[2] = 14'd100;
        tab_x[5] = 14'd45;  tab_y[5] = 14'd100;
        pulse_line(100, 7);
        wait_ready("prio");
        point(47, 7, 40, "prio_overlap");
        point(44, 4, 40, "prio_first_only");
        point(50, 5, 45, "prio_second_only");
        point(54, 9, 45, "prio_second_edge");
    endtask

    task automatic test_overflow();
        clear_table(1000);
        for (int i = 0; i < 6; i++) begin
            tab_x[i] = 14'(100 * i);
            tab_y[i] = 14'd100;
        end
        pulse_line(100, 5);
        wait_ready("ovf");
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_set got=%b want=1", overflow);
        end
        point(5, 5, 0, "ovf_slot0");
        point(305, 5, 300, "ovf_slot3");
        sweep(400, 415, 1'b0, 0, 0, 0, 0, "ovf_dropped4");
        sweep(500, 515, 1'b0, 0, 0, 0, 0, "ovf_dropped5");
        clear_table(1000);
        pulse_line(100, 5);
        total++;
        if (overflow !== 1'b0 || line_ready !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear got ovf=%b rdy=%b want 0 0", overflow, line_ready);
        end
        wait_ready("ovf_clear_line");
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_stays_clear got=%b want=0", overflow);
        end
    endtask

    task automatic test_restart();
        clear_table(1000);
        tab_x[2] = 14'd40;  tab_y[2] = 14'd100;
        tab_x[7] = 14'd200; tab_y[7] = 14'd100;
        pulse_line(100, 3);
        for (int k = 0; k < 8; k++) tick();
        total++;
        if (rd_idx !== 4'd8 || rd_valid !== 1'b1) begin
            bad++;
            $display("FAIL restart_pos got idx=%0d vld=%b want 8 1", rd_idx, rd_valid);
        end
        pulse_line(500, 3);
        total++;
        if (rd_req !== 1'b1 || rd_idx !== 4'd0 || line_ready !== 1'b0) begin
            bad++;
            $display("FAIL restart_idx0 got req=%b idx=%0d rdy=%b want 1 0 0",
                     rd_req, rd_idx, line_ready);
        end
        for (int k = 0; k < 16; k++) tick();
        total++;
        if (line_ready !== 1'b0) begin
            bad++;
            $display("FAIL restart_c17 got rdy=%b want 0", line_ready);
        end
        tick();
        total++;
        if (line_ready !== 1'b1) begin
            bad++;
            $display("FAIL restart_c18 got rdy=%b want 1", line_ready);
        end
        sweep(0, 255, 1'b0, 0, 0, 0, 0, "restart_no_stale");
    endtask

    task automatic test_boundary();
        clear_table(1000);
        tab_x[0] = 14'd40;
        tab_y[0] = 14'd80;
        pulse_line(100, 0);
        wait_ready("bnd80");
        sweep(30, 60, 1'b0, 0, 0, 0, 0, "bnd_end_excl");
        tab_y[0] = 14'd81;
        pulse_line(100, 0);
        wait_ready("bnd81");
        sweep(30, 60, 1'b1, 40, 19, 40, 81, "bnd_last_row");
        tab_y[0] = 14'd0;
        pulse_line(0, 0);
        wait_ready("bnd0");
        sweep(30, 60, 1'b1, 40, 0, 40, 0, "bnd_zero");
    endtask

    task automatic test_rst_priority();
        clear_table(1000);
        pulse_line(100, 5);
        tick();
        tick();
        sys_rst    = 1'b1;
        line_start = 1'b1;
        tick();
        sys_rst    = 1'b0;
        line_start = 1'b0;
        total++;
        if (rd_req !== 1'b0 || rd_idx !== 4'd0 || line_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_over_start got req=%b idx=%0d rdy=%b want 0 0 0",
                     rd_req, rd_idx, line_ready);
        end
        for (int k = 0; k < 20; k++) tick();
        total++;
        if (rd_req !== 1'b0 || line_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_stays_idle got req=%b rdy=%b want 0 0", rd_req, line_ready);
        end
    endtask

    initial begin
        clear_table(0);
        test_reset();
        test_scan_timing();
        test_single();
        test_priority();
        test_overflow();
        test_restart();
        test_boundary();
        test_rst_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
